// File: rtl/seven_seg_scan_decoder_if.sv
// Bus bundle between the switch/encoder logic (master) and the
// seven-segment scan decoder (slave). The master drives the value to
// display and its controls; the slave drives the board display pins.
interface seven_seg_scan_decoder_if;
    logic [15:0] value;   // digit3=[15:12] .. digit0=[3:0]
    logic [3:0]  dp_in;   // per-digit decimal point, active-high
    logic        load;    // one-cycle capture strobe
    logic        en;      // display enable
    logic [3:0]  an;      // anode enables, active-low, an[0] = rightmost
    logic [6:0]  seg7;    // segments g..a, active-low
    logic        dp;      // decimal point, active-low

    modport master (
        output value,
        output dp_in,
        output load,
        output en,
        input  an,
        input  seg7,
        input  dp
    );

    modport slave (
        input  value,
        input  dp_in,
        input  load,
        input  en,
        output an,
        output seg7,
        output dp
    );
endinterface

// File: rtl/seven_seg_scan_decoder.sv
// Four-digit multiplexed seven-segment driver for the BASYS2 display.
//
// A shadow register holds the 16-bit value and the decimal points captured
// on load; the scan logic only ever reads the shadow. Each digit owns a slot
// of DIGIT_TICKS cycles: the first BLANK_TICKS cycles keep every anode off
// so the previous digit's segments never bleed into the next one, then the
// selected anode is driven for the rest of the slot. All display outputs are
// registered and trail the counter/phase state by one cycle.
//
// Optional build macro LEADING_ZERO_BLANK_EN: when defined, digits 3..1 are
// blanked while they and every more significant nibble are zero; digit 0 is
// always shown. The anode timing and the decimal point are unaffected.
module seven_seg_scan_decoder #(
    parameter int unsigned DIGIT_TICKS = 50000,
    parameter int unsigned BLANK_TICKS = 16
) (
    input logic                     clk,
    input logic                     rst,
    seven_seg_scan_decoder_if.slave bus
);

    localparam int unsigned CW = $clog2(DIGIT_TICKS);

    localparam logic [CW-1:0] CNT_LAST   = CW'(DIGIT_TICKS - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_TICKS - 1);

    localparam logic [3:0] AN_OFF  = 4'b1111;
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Reject parameter sets that would give an empty ON or BLANK window.
    if (DIGIT_TICKS < 4) begin : gen_bad_digit_ticks
        $error("DIGIT_TICKS must be >= 4");
    end
    if (BLANK_TICKS < 1 || BLANK_TICKS >= DIGIT_TICKS) begin : gen_bad_blank_ticks
        $error("BLANK_TICKS must be >= 1 and < DIGIT_TICKS");
    end

    typedef enum logic [0:0] {
        StBlank = 1'b0,
        StOn    = 1'b1
    } phase_e;

    // Hex nibble to active-low segment pattern, bit 6 = g .. bit 0 = a.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            default: seg = 7'h0E;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [15:0]   shadow_val_q, shadow_val_d;
    logic [3:0]    shadow_dp_q,  shadow_dp_d;
    logic [CW-1:0] cnt_q,        cnt_d;
    logic [1:0]    idx_q,        idx_d;
    phase_e        phase_q,      phase_d;
    logic [3:0]    an_q,         an_d;
    logic [6:0]    seg_q,        seg_d;
    logic          dp_q,         dp_d;

    logic          slot_end;
    logic [3:0]    cur_nib;
    logic [3:0]    lz_blank;

    assign slot_end = (cnt_q == CNT_LAST);

    // Shadow capture; reset wins over a coincident load.
    always_comb begin
        shadow_val_d = shadow_val_q;
        shadow_dp_d  = shadow_dp_q;
        if (bus.load) begin
            shadow_val_d = bus.value;
            shadow_dp_d  = bus.dp_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_val_q <= 16'h0000;
            shadow_dp_q  <= 4'h0;
        end else begin
            shadow_val_q <= shadow_val_d;
            shadow_dp_q  <= shadow_dp_d;
        end
    end

    // Slot tick counter and digit index; the index steps when a slot wraps.
    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (slot_end) begin
            cnt_d = '0;
            idx_d = idx_q + 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            idx_q <= 2'd0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    // Phase FSM: next-state, entering ON just before the counter leaves
    // the blanking window and BLANK again as the slot wraps.
    always_comb begin
        phase_d = phase_q;
        unique case (phase_q)
            StBlank: if (cnt_q == BLANK_LAST) phase_d = StOn;
            StOn:    if (slot_end)            phase_d = StBlank;
            default: phase_d = StBlank;
        endcase
    end

    // Phase FSM: state register.
    always_ff @(posedge clk) begin
        if (rst) phase_q <= StBlank;
        else     phase_q <= phase_d;
    end

    // Leading-zero suppression mask for the digit being scanned.
`ifdef LEADING_ZERO_BLANK_EN
    always_comb begin
        lz_blank    = 4'b0000;
        lz_blank[3] = (shadow_val_q[15:12] == 4'h0);
        lz_blank[2] = lz_blank[3] && (shadow_val_q[11:8] == 4'h0);
        lz_blank[1] = lz_blank[2] && (shadow_val_q[7:4] == 4'h0);
        lz_blank[0] = 1'b0;
    end
`else
    always_comb begin
        lz_blank = 4'b0000;
    end
`endif

    assign cur_nib = shadow_val_q[{idx_q, 2'b00} +: 4];

    // Display next-state: dark when disabled or blanking, else drive the
    // selected digit. en is used directly so disabling takes effect on the
    // very next edge while the scan keeps running underneath.
    always_comb begin
        an_d  = AN_OFF;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        if (bus.en && (phase_q == StOn)) begin
            an_d  = ~(4'b0001 << idx_q);
            seg_d = lz_blank[idx_q] ? SEG_OFF : hex_to_seg(cur_nib);
            dp_d  = ~shadow_dp_q[idx_q];
        end
    end

    // Registered display pins.
    always_ff @(posedge clk) begin
        if (rst) begin
            an_q  <= AN_OFF;
            seg_q <= SEG_OFF;
            dp_q  <= 1'b1;
        end else begin
            an_q  <= an_d;
            seg_q <= seg_d;
            dp_q  <= dp_d;
        end
    end

    assign bus.an   = an_q;
    assign bus.seg7 = seg_q;
    assign bus.dp   = dp_q;

endmodule
